// File: rtl/lcd_text_formatter_pkg.sv
// -----------------------------------------------------------------------------
// lcd_text_formatter_pkg
// Shared definitions for the LCD text formatter:
//   - ASCII constants used to build the 2x16 character frame
//   - line base address and per-line field offsets
//   - FSM state encoding
//   - helpers that map a field position plus BCD digits to a character
// -----------------------------------------------------------------------------
package lcd_text_formatter_pkg;

  // ASCII / LCD character codes
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_DEGREE = 8'hDF;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_T      = 8'h54;
  localparam logic [7:0] CH_H      = 8'h48;
  localparam logic [7:0] CH_EQ     = 8'h3D;
  localparam logic [7:0] CH_C      = 8'h43;
  localparam logic [7:0] CH_PCT    = 8'h25;

  // Frame geometry: line 0 at 0..15, line 1 at 16..31
  localparam logic [4:0] LINE1_BASE = 5'd16;
  localparam logic [4:0] FRAME_LAST = 5'd31;

  // Field offsets within a line (both lines share the same numeric layout)
  localparam logic [3:0] POS_LABEL  = 4'd0;
  localparam logic [3:0] POS_EQ     = 4'd1;
  localparam logic [3:0] POS_SIGN   = 4'd3;  // line 0 sign / line 1 hundreds
  localparam logic [3:0] POS_TENS   = 4'd4;
  localparam logic [3:0] POS_UNITS  = 4'd5;
  localparam logic [3:0] POS_DOT    = 4'd6;
  localparam logic [3:0] POS_TENTHS = 4'd7;
  localparam logic [3:0] POS_UNIT   = 4'd8;  // degree sign / percent
  localparam logic [3:0] POS_C      = 4'd9;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_LATCH = 3'd2,
    S_BCD_T = 3'd3,
    S_WR_T  = 3'd4,
    S_BCD_H = 3'd5,
    S_WR_H  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  function automatic logic [7:0] digit_ch(input logic [3:0] d);
    return CH_ZERO + {4'h0, d};
  endfunction

  // Line 0 character. bcd = {tens, units, tenths} of |temp|.
  function automatic logic [7:0] t_char(input logic [3:0] pos, input logic [11:0] bcd,
                                        input logic neg, input logic oor);
    logic [7:0] c;
    logic       blank;
    blank = (bcd[11:8] == 4'd0);
    c     = CH_SPACE;
    case (pos)
      POS_LABEL:  c = CH_T;
      POS_EQ:     c = CH_EQ;
      // With tens blanked the minus slides right next to the units digit.
      POS_SIGN:   c = (oor || (neg && !blank)) ? CH_MINUS : CH_SPACE;
      POS_TENS:   c = oor ? CH_MINUS : (blank ? (neg ? CH_MINUS : CH_SPACE) : digit_ch(bcd[11:8]));
      POS_UNITS:  c = oor ? CH_MINUS : digit_ch(bcd[7:4]);
      POS_DOT:    c = CH_DOT;
      POS_TENTHS: c = oor ? CH_MINUS : digit_ch(bcd[3:0]);
      POS_UNIT:   c = CH_DEGREE;
      POS_C:      c = CH_C;
      default:    c = CH_SPACE;
    endcase
    return c;
  endfunction

  // Line 1 character. bcd = {hundreds, tens, units, tenths} of humidity.
  function automatic logic [7:0] h_char(input logic [3:0] pos, input logic [15:0] bcd,
                                        input logic oor);
    logic [7:0] c;
    logic       hund_z;
    hund_z = (bcd[15:12] == 4'd0);
    c      = CH_SPACE;
    case (pos)
      POS_LABEL:  c = CH_H;
      POS_EQ:     c = CH_EQ;
      POS_SIGN:   c = oor ? CH_MINUS : (hund_z ? CH_SPACE : digit_ch(bcd[15:12]));
      POS_TENS:   c = oor ? CH_MINUS :
                      ((hund_z && bcd[11:8] == 4'd0) ? CH_SPACE : digit_ch(bcd[11:8]));
      POS_UNITS:  c = oor ? CH_MINUS : digit_ch(bcd[7:4]);
      POS_DOT:    c = CH_DOT;
      POS_TENTHS: c = oor ? CH_MINUS : digit_ch(bcd[3:0]);
      POS_UNIT:   c = CH_PCT;
      default:    c = CH_SPACE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential double-dabble: 10-bit unsigned binary to 4 BCD digits.
// One shift per cycle; every digit >= 5 gets +3 before each shift.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   start_i       load bin_i and begin conversion (ignored by nothing; restarts)
//   bin_i [9:0]   value to convert, sampled when start_i is high
//   bcd_o [15:0]  {thousands, hundreds, tens, units}; held until next start
//   done_o        high in the 10th cycle after the start cycle, i.e. the
//                 cycle of the final shift; bcd_o is final from the next cycle
// -----------------------------------------------------------------------------
module bin_to_bcd_seq (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        start_i,
  input  logic [9:0]  bin_i,
  output logic [15:0] bcd_o,
  output logic        done_o
);

  logic [9:0]  bin_q;
  logic [15:0] bcd_q;
  logic [3:0]  cnt_q;
  logic [15:0] adj;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      bin_q <= bin_i;
      bcd_q <= '0;
      cnt_q <= 4'd10;
    end else if (cnt_q != 4'd0) begin
      bcd_q <= {adj[14:0], bin_q[9]};
      bin_q <= {bin_q[8:0], 1'b0};
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = (cnt_q == 4'd1);

endmodule

// File: rtl/lcd_text_formatter.sv
// -----------------------------------------------------------------------------
// lcd_text_formatter
// Converts one temperature/humidity sample into a fixed 2x16 character frame
// stored in a 32x8 frame RAM, read by the LCD driver through a registered port.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset (restarts INIT,
//                    abandoning any partial frame)
//   i_valid/o_in_ready  sample handshake
//   i_temp [15:0]    signed temperature, 0.1 degC
//   i_hum  [15:0]    unsigned humidity, 0.1 %RH
//   o_done           one-cycle pulse when a frame is fully written
//   o_frame_cnt[7:0] completed frames, wraps
//   i_rd_addr[9:0]   driver read address
//   o_rd_data[7:0]   RAM[i_rd_addr] one cycle later; 0x20 for addr >= 32
// Handshake: a sample transfers on an edge where i_valid && o_in_ready.
// o_in_ready is high only in IDLE and does not depend on i_valid; i_valid is
// ignored whenever o_in_ready is low.
// Timeline after the accepting edge (cycles): LATCH 1, BCD_T 10, WR_T 16,
// BCD_H 10, WR_H 16, DONE 1 -> o_done in cycle 54, next accept in cycle 55.
// -----------------------------------------------------------------------------
module lcd_text_formatter
  import lcd_text_formatter_pkg::*;
#(
  parameter int T_MIN = -999,
  parameter int T_MAX = 999,
  parameter int H_MAX = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  output logic       o_in_ready,
  input  logic [15:0] i_temp,
  input  logic [15:0] i_hum,
  output logic       o_done,
  output logic [7:0] o_frame_cnt,
  input  logic [9:0] i_rd_addr,
  output logic [7:0] o_rd_data
);

  localparam logic signed [15:0] TMinW = T_MIN[15:0];
  localparam logic signed [15:0] TMaxW = T_MAX[15:0];
  localparam logic [15:0]        HMaxW = H_MAX[15:0];

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  rd_data_q;
  logic [7:0]  ram_q [32];

  logic        t_neg_q, t_oor_q, h_oor_q;
  logic [9:0]  t_mag_q, h_mag_q;

  logic        accept;
  logic        t_oor_c, h_oor_c;
  logic [15:0] t_abs;
  logic        unused_bits;

  logic        we;
  logic [7:0]  wr_data;
  logic        bcd_start, bcd_done;
  logic [9:0]  bcd_in;
  logic [15:0] bcd_val;

  assign accept  = (state_q == S_IDLE) && i_valid;
  assign t_oor_c = ($signed(i_temp) < TMinW) || ($signed(i_temp) > TMaxW);
  assign h_oor_c = (i_hum > HMaxW);
  assign t_abs   = i_temp[15] ? (~i_temp + 16'd1) : i_temp;
  // In-range magnitudes fit 10 bits; the upper bits only matter for the range check.
  assign unused_bits = ^{t_abs[15:10], i_hum[15:10]};

  bin_to_bcd_seq u_bcd (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .start_i (bcd_start),
    .bin_i   (bcd_in),
    .bcd_o   (bcd_val),
    .done_o  (bcd_done)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    we          = 1'b0;
    wr_data     = CH_SPACE;
    bcd_start   = 1'b0;
    bcd_in      = t_mag_q;
    case (state_q)
      S_INIT: begin
        we = 1'b1;
        if (idx_q == FRAME_LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (accept) state_d = S_LATCH;
      end
      S_LATCH: begin
        bcd_start = 1'b1;
        state_d   = S_BCD_T;
      end
      S_BCD_T: begin
        if (bcd_done) state_d = S_WR_T;
      end
      S_WR_T: begin
        we      = 1'b1;
        wr_data = t_char(idx_q[3:0], bcd_val[11:0], t_neg_q, t_oor_q);
        // Humidity conversion starts on the last temperature write; that write
        // still sees the temperature digits because the converter updates at the edge.
        if (idx_q == LINE1_BASE - 5'd1) begin
          bcd_start = 1'b1;
          bcd_in    = h_mag_q;
          state_d   = S_BCD_H;
        end
      end
      S_BCD_H: begin
        bcd_in = h_mag_q;
        if (bcd_done) state_d = S_WR_H;
      end
      S_WR_H: begin
        we      = 1'b1;
        wr_data = h_char(idx_q[3:0], bcd_val, h_oor_q);
        if (idx_q == FRAME_LAST) begin
          state_d     = S_DONE;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
    if (we) idx_d = idx_q + 5'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_INIT;
      idx_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      t_neg_q <= 1'b0;
      t_oor_q <= 1'b0;
      h_oor_q <= 1'b0;
      t_mag_q <= '0;
      h_mag_q <= '0;
    end else if (accept) begin
      t_neg_q <= i_temp[15];
      t_oor_q <= t_oor_c;
      h_oor_q <= h_oor_c;
      t_mag_q <= t_oor_c ? 10'd0 : t_abs[9:0];
      h_mag_q <= h_oor_c ? 10'd0 : i_hum[9:0];
    end
  end

  // Frame RAM: write port from the FSM, registered read-before-write port.
  always_ff @(posedge i_clk) begin
    if (we && !i_rst) ram_q[idx_q] <= wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_data_q <= CH_SPACE;
    end else if (i_rd_addr < 10'd32) begin
      rd_data_q <= ram_q[i_rd_addr[4:0]];
    end else begin
      rd_data_q <= CH_SPACE;
    end
  end

  assign o_in_ready  = (state_q == S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_frame_cnt = frame_cnt_q;
  assign o_rd_data   = rd_data_q;

endmodule

// File: tb/tb_lcd_text_formatter.sv
// -----------------------------------------------------------------------------
// tb_lcd_text_formatter
// Directed vectors with hand-written expected frames. Drivers push expected
// read bytes and expected o_done cycles/frame counts into queues; monitors on
// the falling edge pop and compare whenever the DUT presents a read result or
// an o_done pulse.
// -----------------------------------------------------------------------------
module tb_lcd_text_formatter;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic       o_in_ready;
  logic [15:0] i_temp = '0;
  logic [15:0] i_hum = '0;
  logic       o_done;
  logic [7:0] o_frame_cnt;
  logic [9:0] i_rd_addr = '0;
  logic [7:0] o_rd_data;

  always #5 clk = ~clk;

  lcd_text_formatter dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_in_ready  (o_in_ready),
    .i_temp      (i_temp),
    .i_hum       (i_hum),
    .o_done      (o_done),
    .o_frame_cnt (o_frame_cnt),
    .i_rd_addr   (i_rd_addr),
    .o_rd_data   (o_rd_data)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // scoreboard queues
  logic [7:0] exp_q[$];
  int         exp_addr_q[$];
  int         exp_done_q[$];
  logic [7:0] exp_cnt_q[$];

  logic       rd_req = 1'b0;
  logic       rd_pend = 1'b0;
  int         done_seen = 0;
  int         done_target = 0;
  logic [7:0] cnt_model = 8'd0;
  logic [7:0] exp_frame[32];

  logic [7:0] mon_e;
  int         mon_a;
  int         mon_c;
  logic [7:0] mon_n;

  // ---------------- clock/reset helpers and checks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitors ----------------
  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    if (rd_pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got %0h (cycle %0d)", o_rd_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = exp_addr_q.pop_front();
        if (o_rd_data !== mon_e) begin
          errors++;
          $display("FAIL rd addr %0d got %0h expected %0h (cycle %0d)", mon_a, o_rd_data, mon_e, cyc);
        end
      end
    end
    if (!i_rst && o_done === 1'b1) begin
      done_seen++;
      checks++;
      if (exp_done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected at cycle %0d", cyc);
      end else begin
        mon_c = exp_done_q.pop_front();
        mon_n = exp_cnt_q.pop_front();
        if (cyc != mon_c) begin
          errors++;
          $display("FAIL done_cycle got %0d expected %0d", cyc, mon_c);
        end
        checks++;
        if (o_frame_cnt !== mon_n) begin
          errors++;
          $display("FAIL done_frame_cnt got %0d expected %0d", o_frame_cnt, mon_n);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rd(input int addr, input logic [7:0] exp);
    i_rd_addr = 10'(addr);
    rd_req    = 1'b1;
    exp_q.push_back(exp);
    exp_addr_q.push_back(addr);
    step();
    rd_req = 1'b0;
  endtask

  task automatic wait_ready(output int at_cyc);
    int n;
    n = 0;
    while (o_in_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (o_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got %0b expected 1 (cycle %0d)", o_in_ready, cyc);
    end
    at_cyc = cyc;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_seen < done_target && n < 200) begin
      step();
      n++;
    end
    chk("done_timeout", 32'(done_seen), 32'(done_target));
  endtask

  task automatic accept(input int t, input int h, output int a);
    int r;
    wait_ready(r);
    i_temp  = 16'(t);
    i_hum   = 16'(h);
    i_valid = 1'b1;
    step();
    a       = cyc;
    i_valid = 1'b0;
  endtask

  task automatic load_frame(input string l0, input string l1);
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = l0[i];
      exp_frame[i] = (b == 8'h7E) ? 8'hDF : b;  // '~' stands for the degree glyph
      b = l1[i];
      exp_frame[16+i] = b;
    end
  endtask

  task automatic check_frame();
    for (int a = 0; a < 32; a++) rd(a, exp_frame[a]);
    rd(40, 8'h20);
    step();
    step();
  endtask

  task automatic run_frame(input int t, input int h, input string l0, input string l1,
                           input bit poke);
    int a;
    accept(t, h, a);
    cnt_model = cnt_model + 8'd1;
    exp_done_q.push_back(a + 53);
    exp_cnt_q.push_back(cnt_model);
    done_target++;
    if (poke) begin
      // valid held with different data while busy must be ignored
      i_temp  = 16'd777;
      i_hum   = 16'd3;
      i_valid = 1'b1;
      while (cyc < a + 40) step();
      i_valid = 1'b0;
    end
    wait_done();
    load_frame(l0, l1);
    check_frame();
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int rel, a, a0, last, r;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(o_in_ready), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    chk("rst_rd_data", 32'(o_rd_data), 32'h20);
    step();
    i_rst = 1'b0;
    rel   = cyc;
    wait_ready(r);
    chk("init_ready_latency", 32'(r - rel), 32'd32);
    chk("init_frame_cnt", 32'(o_frame_cnt), 32'd0);
    load_frame("                ", "                ");
    check_frame();

    // directed vectors
    run_frame(235,   456,  "T=  23.5~C      ", "H=  45.6%       ", 1'b1);
    run_frame(-5,    1000, "T=  -0.5~C      ", "H= 100.0%       ", 1'b0);
    run_frame(1000,  1001, "T= ---.-~C      ", "H= ---.-%       ", 1'b0);
    run_frame(-123,  5,    "T= -12.3~C      ", "H=   0.5%       ", 1'b0);
    run_frame(-999,  0,    "T= -99.9~C      ", "H=   0.0%       ", 1'b0);
    run_frame(-1000, 999,  "T= ---.-~C      ", "H=  99.9%       ", 1'b0);
    run_frame(50,    100,  "T=   5.0~C      ", "H=  10.0%       ", 1'b0);

    // reset in the middle of a frame
    accept(-123, 5, a);
    while (cyc < a + 19) step();
    i_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_rd_data", 32'(o_rd_data), 32'h20);
    chk("midrst_done", 32'(o_done), 32'd0);
    chk("midrst_in_ready", 32'(o_in_ready), 32'd0);
    step();
    i_rst = 1'b0;
    rel   = cyc;
    cnt_model = 8'd0;
    rd(0, 8'h54);   // INIT writes addr 0 on this same edge: old byte
    rd(1, 8'h3D);   // same for addr 1
    rd(0, 8'h20);   // now rewritten
    rd(40, 8'h20);
    wait_ready(r);
    chk("midrst_ready_latency", 32'(r - rel), 32'd32);
    chk("midrst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    load_frame("                ", "                ");
    check_frame();

    // i_valid held high for 256 frames
    wait_ready(r);
    i_temp  = 16'd235;
    i_hum   = 16'd456;
    i_valid = 1'b1;
    step();
    a0 = cyc;
    for (int k = 0; k < 256; k++) begin
      cnt_model = cnt_model + 8'd1;
      exp_done_q.push_back(a0 + 55 * k + 53);
      exp_cnt_q.push_back(cnt_model);
    end
    done_target += 256;
    last = a0 + 55 * 255;
    while (cyc < last + 1) step();
    i_valid = 1'b0;
    wait_done();
    step();
    chk("wrap_frame_cnt", 32'(o_frame_cnt), 32'd0);
    load_frame("T=  23.5~C      ", "H=  45.6%       ");
    check_frame();

    repeat (5) step();
    chk("done_queue_empty", 32'(exp_done_q.size()), 32'd0);
    chk("rd_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
